// File: rtl/sha_nonce_scheduler_pkg.sv
// Shared SHA-256 types, padding constants and block-building helper
// used by the nonce scheduler and its neighbours.
package sha_nonce_scheduler_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } hash_state_t;

    localparam int ROUNDS      = 64;
    localparam int TAIL_WORDS  = 3;
    localparam int BLOCK_WORDS = 16;

    localparam logic [31:0] PAD_START = 32'h8000_0000;
    localparam logic [31:0] PAD_LEN   = 32'h0000_0280;

    typedef logic [BLOCK_WORDS-1:0][31:0] block_t;
    typedef logic [TAIL_WORDS-1:0][31:0]  tail_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // Second block of an 80-byte header: tail, nonce, then fixed padding.
    function automatic block_t build_block(
        input tail_t       tail,
        input logic [31:0] nonce
    );
        block_t w;
        w     = '0;
        w[0]  = tail[0];
        w[1]  = tail[1];
        w[2]  = tail[2];
        w[3]  = nonce;
        w[4]  = PAD_START;
        w[15] = PAD_LEN;
        return w;
    endfunction

endpackage

// File: rtl/sha_valid_tracker.sv
// Validity shift register mirroring the in-flight contents of the
// round pipeline; the tail bit qualifies the pipeline result.
module sha_valid_tracker #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic shift,
    output logic tail_valid,
    output logic drained
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(shift);
        end
    end

    assign tail_valid = sr[DEPTH-1];

    // True when nothing except the result retiring this cycle remains.
    assign drained = ((sr << 1) == '0);

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Issues consecutive nonces into a 64-round SHA pipeline and retires
// results in order, stopping on the first leading-zero hit.
module sha_nonce_scheduler
    import sha_nonce_scheduler_pkg::*;
#(
    parameter int ROUND_PIPELINE_DEPTH = 1,
    parameter int ZERO_BITS            = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  hash_state_t midstate_i,
    input  tail_t       tail_i,
    input  logic [31:0] nonce_first_i,
    input  logic [31:0] nonce_last_i,
    output hash_state_t pipe_state_o,
    output block_t      pipe_W_o,
    output logic        pipe_valid_o,
    input  hash_state_t pipe_state_i,
    output logic        busy_o,
    output logic        found_o,
    output logic        exhausted_o,
    output logic [31:0] nonce_o
);

    localparam int LATENCY = ROUNDS * ROUND_PIPELINE_DEPTH;

    sched_state_t state;
    sched_state_t next;

    hash_state_t midstate;
    tail_t       tail;
    logic [31:0] nonce_last;
    logic [31:0] issue_cnt;
    logic [31:0] retire_cnt;

    logic out_valid;
    logic drained;
    logic hit;
    logic flush;
    logic accept;
    logic set_found;
    logic set_exh;
    logic clear_status;

    logic [ZERO_BITS-1:0] top_bits;
    logic                 unused_state;

    sha_valid_tracker #(
        .DEPTH(LATENCY)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .shift     (pipe_valid_o),
        .tail_valid(out_valid),
        .drained   (drained)
    );

    assign top_bits     = pipe_state_i.a[31 -: ZERO_BITS];
    assign hit          = out_valid && (top_bits == '0);
    assign unused_state = ^pipe_state_i;

    assign pipe_state_o = midstate;
    assign pipe_W_o     = build_block(tail, issue_cnt);
    assign busy_o       = (state == ST_ISSUE) || (state == ST_DRAIN);

    always_comb begin
        next         = state;
        pipe_valid_o = 1'b0;
        flush        = 1'b0;
        accept       = 1'b0;
        set_found    = 1'b0;
        set_exh      = 1'b0;
        clear_status = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    accept = 1'b1;
                    next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    flush        = 1'b1;
                    clear_status = 1'b1;
                    next         = ST_IDLE;
                end else if (hit) begin
                    flush     = 1'b1;
                    set_found = 1'b1;
                    next      = ST_DONE;
                end else begin
                    pipe_valid_o = 1'b1;
                    if (issue_cnt == nonce_last) begin
                        next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Abort beats a hit, and a hit on the final result beats exhaustion.
                if (abort_i) begin
                    flush        = 1'b1;
                    clear_status = 1'b1;
                    next         = ST_IDLE;
                end else if (hit) begin
                    flush     = 1'b1;
                    set_found = 1'b1;
                    next      = ST_DONE;
                end else if (drained) begin
                    set_exh = 1'b1;
                    next    = ST_DONE;
                end
            end
            default: begin
                next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            midstate    <= '0;
            tail        <= '0;
            nonce_last  <= '0;
            issue_cnt   <= '0;
            retire_cnt  <= '0;
            found_o     <= 1'b0;
            exhausted_o <= 1'b0;
            nonce_o     <= '0;
        end else begin
            state <= next;
            if (accept) begin
                midstate    <= midstate_i;
                tail        <= tail_i;
                nonce_last  <= nonce_last_i;
                issue_cnt   <= nonce_first_i;
                retire_cnt  <= nonce_first_i;
                found_o     <= 1'b0;
                exhausted_o <= 1'b0;
                nonce_o     <= '0;
            end else begin
                if (pipe_valid_o) begin
                    issue_cnt <= issue_cnt + 32'd1;
                end
                if (out_valid) begin
                    retire_cnt <= retire_cnt + 32'd1;
                end
                if (set_found) begin
                    found_o <= 1'b1;
                    nonce_o <= retire_cnt;
                end
                if (set_exh) begin
                    exhausted_o <= 1'b1;
                end
                if (clear_status) begin
                    found_o     <= 1'b0;
                    exhausted_o <= 1'b0;
                end
            end
        end
    end

endmodule
